// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: per-stage enables/flushes, load-use bubble, redirect squash, data-memory freeze.
// Outputs are combinational from state and inputs; a memory access freezes all stages from detect until the MEMDONE advance.
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_regwrt,
  input  logic             i_ex_memread,
  input  logic             i_redirect,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic             i_dmem_ready,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_dmem_req,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {RUN, MEMREQ, MEMDONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_mem_op;
  logic             w_loaduse;
  logic             w_freeze;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_mem_op  = i_mem_rd | i_mem_wr;
  assign w_loaduse = i_ex_memread & i_ex_regwrt &
                     ((i_id_use_rs & (i_id_rs == i_ex_rd)) |
                      (i_id_use_rt & (i_id_rt == i_ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (w_mem_op) w_next = MEMREQ;
      MEMREQ:  if (i_dmem_ready) w_next = MEMDONE;
      MEMDONE: w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    o_pc_en      = 1'b0;
    o_ifid_en    = 1'b0;
    o_idex_en    = 1'b0;
    o_exmem_en   = 1'b0;
    o_memwb_en   = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_dmem_req   = 1'b0;
    w_freeze     = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      RUN:     w_freeze = w_mem_op;
      MEMREQ:  w_freeze = 1'b1;
      default: w_freeze = 1'b0;
    endcase
    if (!rst) begin
      if (w_freeze) begin
        o_dmem_req  = 1'b1;
        w_stall_inc = 1'b1;
      end else if (i_redirect) begin
        // Any load-use stall here belongs to a wrong-path instruction.
        {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b11111;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
        w_flush_inc  = 1'b1;
      end else if (w_loaduse) begin
        {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b00111;
        o_idex_flush = 1'b1;
        w_stall_inc  = 1'b1;
      end else begin
        {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = 5'b11111;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, redirects, memory freeze, counter saturation and reset.
module tb_pipe_ctrl;
  localparam int CNT_W = 16;
  localparam int REG_W = 6;
  localparam logic [7:0] ZERO    = 8'b00000_00_0;
  localparam logic [7:0] NORMAL  = 8'b11111_00_0;
  localparam logic [7:0] FREEZE  = 8'b00000_00_1;
  localparam logic [7:0] LOADUSE = 8'b00111_01_0;
  localparam logic [7:0] REDIR   = 8'b11111_11_0;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_use_rs, id_use_rt, ex_regwrt, ex_memread;
  logic             redirect, mem_rd, mem_wr, dmem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, dmem_req;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]       obs;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, dmem_req};

  pipe_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_ex_rd(ex_rd), .i_ex_regwrt(ex_regwrt), .i_ex_memread(ex_memread),
    .i_redirect(redirect), .i_mem_rd(mem_rd), .i_mem_wr(mem_wr), .i_dmem_ready(dmem_ready),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_dmem_req(dmem_req), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_regwrt = 0; ex_memread = 0;
    redirect = 0; mem_rd = 0; mem_wr = 0; dmem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk); rst = 0;
    cyc();
  endtask

  task automatic set_loaduse(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                             input logic [REG_W-1:0] rt, input logic urs, input logic urt);
    ex_memread = 1; ex_regwrt = 1; ex_rd = rd;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; mem_rd = 1; redirect = 1; dmem_ready = 1;
    set_loaduse(6'd5, 6'd5, 6'd5, 1, 1);
    #1;
    checks++; if (obs !== ZERO) begin errors++; $display("FAIL reset_outs got %b want %b", obs, ZERO); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush got %0d want 0", flush_cnt); end
    cyc();
    checks++; if (obs !== ZERO) begin errors++; $display("FAIL reset_held got %b want %b", obs, ZERO); end
    clear_inputs();
    @(negedge clk); rst = 0; #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL release_normal got %b want %b", obs, NORMAL); end
    cyc();
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL release_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_loaduse();
    do_reset();
    set_loaduse(6'd5, 6'd5, 6'd0, 1, 0); #1;
    checks++; if (obs !== LOADUSE) begin errors++; $display("FAIL lu_rs got %b want %b", obs, LOADUSE); end
    cyc(); clear_inputs(); #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL lu_after got %b want %b", obs, NORMAL); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall1 got %0d want 1", stall_cnt); end
    set_loaduse(6'd5, 6'd5, 6'd5, 0, 0); #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL lu_unused got %b want %b", obs, NORMAL); end
    cyc();
    set_loaduse(6'd9, 6'd3, 6'd9, 0, 1); #1;
    checks++; if (obs !== LOADUSE) begin errors++; $display("FAIL lu_rt got %b want %b", obs, LOADUSE); end
    cyc();
    set_loaduse(6'd9, 6'd9, 6'd9, 1, 1); ex_regwrt = 0; #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL lu_noregwrt got %b want %b", obs, NORMAL); end
    cyc();
    set_loaduse(6'd0, 6'd0, 6'd7, 1, 0); #1;
    checks++; if (obs !== LOADUSE) begin errors++; $display("FAIL lu_r0 got %b want %b", obs, LOADUSE); end
    cyc(); clear_inputs(); #1;
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL lu_stall3 got %0d want 3", stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_loaduse(6'd5, 6'd5, 6'd0, 1, 0); redirect = 1; #1;
    checks++; if (obs !== REDIR) begin errors++; $display("FAIL redir_lu got %b want %b", obs, REDIR); end
    cyc(); clear_inputs(); #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL redir_after got %b want %b", obs, NORMAL); end
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL redir_cnts got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    int reqs = 0;
    do_reset();
    mem_rd = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      checks++; if (obs !== FREEZE) begin errors++; $display("FAIL memwait_frz%0d got %b want %b", i, obs, FREEZE); end
      if (dmem_req) reqs++;
      cyc();
    end
    dmem_ready = 0; #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL memwait_done got %b want %b", obs, NORMAL); end
    checks++; if (reqs !== 4) begin errors++; $display("FAIL memwait_reqs got %0d want 4", reqs); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL memwait_stall got %0d want 4", stall_cnt); end
    cyc(); mem_rd = 0; #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL memwait_run got %b want %b", obs, NORMAL); end
  endtask

  task automatic test_redirect_in_memreq();
    do_reset();
    mem_wr = 1; #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL rim_detect got %b want %b", obs, FREEZE); end
    cyc(); redirect = 1; #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL rim_req1 got %b want %b", obs, FREEZE); end
    cyc(); dmem_ready = 1; #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL rim_req2 got %b want %b", obs, FREEZE); end
    cyc(); dmem_ready = 0; #1;
    checks++; if (obs !== REDIR) begin errors++; $display("FAIL rim_done got %b want %b", obs, REDIR); end
    cyc(); clear_inputs(); #1;
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin errors++; $display("FAIL rim_cnts got %0d/%0d want 1/3", flush_cnt, stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_rd = 1; dmem_ready = 1; #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL b2b_detect1 got %b want %b", obs, FREEZE); end
    cyc(); #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL b2b_req1 got %b want %b", obs, FREEZE); end
    cyc(); #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL b2b_done1 got %b want %b", obs, NORMAL); end
    cyc(); #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL b2b_detect2 got %b want %b", obs, FREEZE); end
    cyc(); #1;
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL b2b_req2 got %b want %b", obs, FREEZE); end
    cyc(); set_loaduse(6'd4, 6'd4, 6'd0, 1, 0); #1;
    checks++; if (obs !== LOADUSE) begin errors++; $display("FAIL b2b_done2_lu got %b want %b", obs, LOADUSE); end
    cyc(); clear_inputs(); #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL b2b_run got %b want %b", obs, NORMAL); end
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL b2b_stall got %0d want 5", stall_cnt); end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    mem_rd = 1;
    repeat (65534) cyc();
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", stall_cnt); end
    repeat (3) cyc();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stall_cnt); end
    checks++; if (obs !== FREEZE) begin errors++; $display("FAIL sat_memreq got %b want %b", obs, FREEZE); end
    #2 rst = 1; #1;
    checks++; if (obs !== ZERO) begin errors++; $display("FAIL midreq_rst got %b want %b", obs, ZERO); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midreq_cnt got %h want 0", stall_cnt); end
    mem_rd = 0;
    @(negedge clk); rst = 0; #1;
    checks++; if (obs !== NORMAL) begin errors++; $display("FAIL midreq_run got %b want %b", obs, NORMAL); end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_loaduse();
    test_redirect();
    test_mem_wait();
    test_redirect_in_memreq();
    test_back_to_back();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage datapath. Generates per-stage load-enable and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the whole pipeline across multi-cycle data-memory accesses through a req/ready handshake. Keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt
- REG_W, 6, width of register specifiers, matching rd in ID/EX
- clk  in  1  system clock; controller state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_rd  in  REG_W  destination register held in ID/EX
- ex_regwrt, ex_memread  in  1  RegWrt and memRead held in ID/EX
- redirect  in  1  EX has resolved a taken branch (BranchZ/BranchN), Jump or JumpMem
- mem_rd, mem_wr  in  1  memRead / memWrite held in EX/MEM
- dmem_ready  in  1  data memory has completed the requested access
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  load enable per register
- ifid_flush, idex_flush  out  1  load a bubble (all controls 0) instead of the input; valid only with matching _en=1
- dmem_req  out  1  data-memory access request
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- FSM states: RUN, MEMREQ, MEMDONE. Reset state RUN.
- Outputs are combinational from registered state and current inputs; rst=1 forces all enables, flushes and dmem_req to 0.
- Conditions:
  - mem_op = mem_rd | mem_wr
  - loaduse = ex_memread & ex_regwrt & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)); no register is exempt.
- RUN:
  - mem_op=1: freeze (all enables 0, flushes 0), dmem_req=1, next MEMREQ; redirect and loaduse ignored.
  - else evaluate "advance rules" below; stay RUN.
- MEMREQ: freeze, dmem_req=1. dmem_ready=1 gives next MEMDONE, else stay.
- MEMDONE: dmem_req=0, mem_op ignored, evaluate advance rules, next RUN. The completed access leaves EX/MEM on this cycle.
- Advance rules, priority redirect > loaduse > normal:
  - redirect: all enables 1, ifid_flush=1, idex_flush=1. The load-use stall is dropped because it is wrong-path.
  - loaduse: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. This inserts one bubble.
  - normal: all enables 1, flushes 0.
- Counters (rising edge, saturate at all-ones, reset 0):
  - stall_cnt +1 on every freeze cycle and every loaduse stall cycle.
  - flush_cnt +1 on every redirect cycle taken.
- dmem_ready outside MEMREQ is ignored. dmem_req stays high until ready; the memory must hold the result until the MEMDONE advance.

## Timing
- State and counters update on the clk rising edge. Pipeline registers sample the outputs on the following falling edge; outputs settle within half a cycle.
- Load-use costs exactly 1 bubble cycle. Redirect costs 2 squashed instructions (IF/ID, ID/EX) and no extra cycle.
- Memory access: 1 RUN-detect cycle + N≥1 MEMREQ cycles + 1 MEMDONE cycle.
  - With ready in the first MEMREQ cycle, the pipeline is frozen 2 cycles.
  - Back-to-back memory instructions each pay the full sequence.
- Reset asserted mid-access: state goes to RUN immediately and dmem_req drops asynchronously. The memory must abort.
- Reset release: the first rising edge evaluates RUN with current inputs.

## Test plan
- Reset: rst=1 with arbitrary inputs -> all outputs 0, counters 0. Release with no hazards -> all enables 1, flushes 0.
- Load-use: ex_memread=1, ex_regwrt=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1. Same case with id_use_rs=0 -> no stall.
- Redirect with simultaneous load-use -> ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_rd=1, dmem_ready after 3 MEMREQ cycles -> dmem_req high 4 cycles, freeze 4 cycles, MEMDONE advance, stall_cnt=4.
- Redirect during MEMREQ -> ignored until MEMDONE; if still high then, flush applied.
- Saturation: preload stall_cnt to 0xFFFE, then 3 stall cycles -> stall_cnt holds 0xFFFF. Assert rst mid-MEMREQ -> dmem_req=0 immediately, state RUN.
